// File: rtl/digit_scan_mux_pkg.sv
// Shared display types and constants for the digit scan mux (package display_pkg).
package display_pkg;

    typedef enum logic [0:0] {
        SCAN_DEAD  = 1'b0,
        SCAN_DRIVE = 1'b1
    } scan_state_e;

    localparam logic [0:0] S_DEAD  = SCAN_DEAD;
    localparam logic [0:0] S_DRIVE = SCAN_DRIVE;

    localparam int SEG_W_DEFAULT = 7;
    localparam logic [SEG_W_DEFAULT-1:0] SEG_OFF = '1;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/digit_scan_mux_if.sv
// Display bus between the formatting logic and the scan driver.
// Optional brightness input exists only when DIGIT_SCAN_DIMMING_EN is defined.
interface digit_scan_mux_if #(
    parameter int NUM_DIGITS = 4,
    parameter int SEG_W      = 7
);
    logic [NUM_DIGITS*SEG_W-1:0] seg_in;
    logic [NUM_DIGITS-1:0]       dp_in;
    logic [NUM_DIGITS-1:0]       digit_en;
    logic                        blank;
    logic [NUM_DIGITS-1:0]       rd;
    logic [SEG_W-1:0]            seg;
    logic                        dp;
    logic                        frame_tick;
`ifdef DIGIT_SCAN_DIMMING_EN
    logic [3:0]                  brightness;

    modport master (output seg_in, dp_in, digit_en, blank, brightness,
                    input  rd, seg, dp, frame_tick);
    modport slave  (input  seg_in, dp_in, digit_en, blank, brightness,
                    output rd, seg, dp, frame_tick);
`else
    modport master (output seg_in, dp_in, digit_en, blank,
                    input  rd, seg, dp, frame_tick);
    modport slave  (input  seg_in, dp_in, digit_en, blank,
                    output rd, seg, dp, frame_tick);
`endif
endinterface

// File: rtl/digit_scan_mux_scan_timer.sv
// Slot counter and digit index for the scan driver.
module scan_timer
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int PRESCALE    = 50000,
    parameter int DEAD_CYCLES = 2,
    localparam int IW = idx_width(NUM_DIGITS),
    localparam int CW = $clog2(PRESCALE)
) (
    input  logic          clk,
    input  logic          reset,
    output logic [IW-1:0] idx_o,
    output logic          slot_end_o,
    output logic          in_dead_o,
    output logic          frame_wrap_o
);
    logic [CW-1:0] slot_cnt_q, slot_cnt_d;
    logic [IW-1:0] idx_q, idx_d;

    always_comb begin
        slot_end_o   = (slot_cnt_q == CW'(PRESCALE - 1));
        frame_wrap_o = slot_end_o && (idx_q == IW'(NUM_DIGITS - 1));
        slot_cnt_d   = slot_end_o ? '0 : slot_cnt_q + 1'b1;
        idx_d        = idx_q;
        if (slot_end_o)
            idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        // Looks at the next count so the FSM register lines up with slot_cnt_q.
        in_dead_o    = int'(slot_cnt_d) < DEAD_CYCLES;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt_q <= '0;
            idx_q      <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            idx_q      <= idx_d;
        end
    end

    assign idx_o = idx_q;

endmodule

// File: rtl/digit_scan_mux.sv
// Time-multiplexed common-anode seven-segment driver with dead time between digits.
// Define DIGIT_SCAN_DIMMING_EN to add 4-bit PWM brightness control.
module digit_scan_mux
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SEG_W       = SEG_W_DEFAULT,
    parameter int PRESCALE    = 50000,
    parameter int DEAD_CYCLES = 2,
    localparam int IW = idx_width(NUM_DIGITS)
) (
    input  logic            clk,
    input  logic            reset,
    digit_scan_mux_if.slave bus
);
    logic [IW-1:0]         idx;
    logic                  slot_end, in_dead, frame_wrap;
    logic [0:0]            state_q, state_d;
    logic                  pwm_on, drive;
    logic [NUM_DIGITS-1:0] rd_q, rd_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic                  dp_q, dp_d, frame_tick_q;

    scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .PRESCALE   (PRESCALE),
        .DEAD_CYCLES(DEAD_CYCLES)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .idx_o       (idx),
        .slot_end_o  (slot_end),
        .in_dead_o   (in_dead),
        .frame_wrap_o(frame_wrap)
    );

`ifdef DIGIT_SCAN_DIMMING_EN
    logic [3:0] pwm_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) pwm_cnt_q <= '0;
        else       pwm_cnt_q <= pwm_cnt_q + 4'd1;
    end

    assign pwm_on = pwm_cnt_q < bus.brightness;
`else
    assign pwm_on = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_DEAD:  if (!in_dead) state_d = S_DRIVE;
            S_DRIVE: if (slot_end && DEAD_CYCLES > 0) state_d = S_DEAD;
            default: state_d = S_DEAD;
        endcase
    end

    // Disabled digits still consume their slot so duty stays uniform.
    always_comb begin
        drive = (state_q == S_DRIVE) && bus.digit_en[idx] && !bus.blank && pwm_on;
        rd_d  = '1;
        seg_d = '1;
        dp_d  = 1'b1;
        if (drive) begin
            rd_d[idx] = 1'b0;
            seg_d     = ~bus.seg_in[idx*SEG_W +: SEG_W];
            dp_d      = ~bus.dp_in[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_DEAD;
            rd_q         <= '1;
            seg_q        <= '1;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_q         <= rd_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_wrap;
        end
    end

    assign bus.rd         = rd_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Bench for digit_scan_mux: directed phases plus random data against a position-arithmetic model.
module tb_digit_scan_mux;
    import display_pkg::*;

    localparam int N = 4;
    localparam int W = 7;
    localparam int P = 8;
    localparam int D = 2;

    logic clk = 1'b0;
    logic reset;

    digit_scan_mux_if #(.NUM_DIGITS(N), .SEG_W(W)) bus();

    digit_scan_mux #(
        .NUM_DIGITS (N),
        .SEG_W      (W),
        .PRESCALE   (P),
        .DEAD_CYCLES(D)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int c      = 0;
    int ticks;
    logic [N-1:0] e_rd;
    logic [W-1:0] e_seg;
    logic         e_dp, e_ft;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h (cycle pos %0d)", tag, obs, exp, c);
    endtask

    // Expected outputs after the next edge, from the position in the frame since reset.
    task automatic predict();
        int p, i, s;
        bit on;
        if (reset) begin
            e_rd = '1; e_seg = SEG_OFF; e_dp = 1'b1; e_ft = 1'b0;
            c = 0;
        end else begin
            p  = c % (N * P);
            i  = p / P;
            s  = p % P;
            on = (s >= D) && bus.digit_en[i] && !bus.blank;
`ifdef DIGIT_SCAN_DIMMING_EN
            on = on && ((c % 16) < int'(bus.brightness));
`endif
            e_rd  = '1;
            e_seg = '1;
            e_dp  = 1'b1;
            if (on) begin
                e_rd[i] = 1'b0;
                e_seg   = ~bus.seg_in[i*W +: W];
                e_dp    = ~bus.dp_in[i];
            end
            e_ft = (i == N - 1) && (s == P - 1);
            c++;
        end
    endtask

    task automatic step();
        predict();
        @(negedge clk);
        check("rd", bus.rd, e_rd);
        check("seg", bus.seg, e_seg);
        check("dp", bus.dp, e_dp);
        check("frame_tick", bus.frame_tick, e_ft);
        check("rd_at_most_one_low", ($countones(~bus.rd) <= 1), 1);
        if (bus.frame_tick) ticks++;
        bus.seg_in = {$urandom, $urandom};
        bus.dp_in  = N'($urandom);
    endtask

    initial begin
        reset        = 1'b1;
        bus.seg_in   = {$urandom, $urandom};
        bus.dp_in    = '0;
        bus.digit_en = '1;
        bus.blank    = 1'b0;
`ifdef DIGIT_SCAN_DIMMING_EN
        bus.brightness = 4'd15;
`endif
        ticks = 0;

        // Reset for three cycles, then the first drive arrives on the third edge.
        repeat (3) step();
        check("reset_rd", bus.rd, 4'b1111);
        check("reset_seg", bus.seg, 7'h7F);
        reset = 1'b0;
        step(); step();
        check("dead_rd", bus.rd, 4'b1111);
        step();
        check("first_drive_rd", bus.rd, 4'b1110);

        // Free run: two frame ticks in 64 cycles.
        ticks = 0;
        repeat (64) step();
        check("frame_ticks_64", ticks, 2);

        // Digit 2 disabled.
        bus.digit_en = 4'b1011;
        ticks = 0;
        repeat (32) step();
        check("frame_ticks_en", ticks, 1);
        bus.digit_en = '1;

        // Blank for 10 cycles in the middle of digit 1's slot.
        while (c % (N * P) != P + 3) step();
        bus.blank = 1'b1;
        repeat (10) step();
        bus.blank = 1'b0;
        repeat (30) step();

        // Reset during digit 3's drive window.
        while (c % (N * P) != 3 * P + 4) step();
        reset = 1'b1;
        step();
        check("midreset_rd", bus.rd, 4'b1111);
        check("midreset_ft", bus.frame_tick, 0);
        reset = 1'b0;
        repeat (20) step();

`ifdef DIGIT_SCAN_DIMMING_EN
        bus.brightness = 4'd4;
        repeat (64) step();
        bus.brightness = 4'd0;
        repeat (32) step();
        check("dark_rd", bus.rd, 4'b1111);
        bus.brightness = 4'd15;
`endif

        // Random mix of enables, blanking, brightness and occasional reset.
        repeat (400) begin
            bus.digit_en = N'($urandom);
            bus.blank    = ($urandom_range(0, 9) == 0);
            reset        = ($urandom_range(0, 99) == 0);
`ifdef DIGIT_SCAN_DIMMING_EN
            bus.brightness = 4'($urandom);
`endif
            step();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
